// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
// The master modport is the fetch queue side. The slave modport is the memory/decode side.
interface inst_fetch_queue_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic        inst_is_32_o;
  logic [31:0] inst_pc_o;

  modport master (
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_is_32_o, inst_pc_o,
    input  imem_valid_i, imem_data_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_is_32_o, inst_pc_o,
    output imem_valid_i, imem_data_i
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Thumb fetch front-end: fetches 32-bit words, queues them as halfwords and
// presents one complete 16- or 32-bit instruction per cycle to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [31:0]         flush_pc_i,
  inst_fetch_queue_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t        REQ_LIMIT   = cnt_t'(DEPTH - 4);
  localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

  logic [15:0] mem_q [DEPTH];
  ptr_t        head_q, tail_q;
  cnt_t        count_q;
  logic [31:0] fetch_pc_q, head_pc_q;
  logic        skip_low_q;
  logic        req_q;

  logic [15:0] head_lo, head_hi;
  logic        head_is_prefix;
  logic        inst_valid;
  logic        req;
  logic        push, pop;
  cnt_t        push_n, pop_n;

  assign head_lo = mem_q[head_q];
  assign head_hi = mem_q[head_q + ptr_t'(1)];

  // 5'b11101, 5'b11110 and 5'b11111 are the first halves of two-halfword instructions.
  assign head_is_prefix = (head_lo[15:13] == 3'b111) && (head_lo[12:11] != 2'b00);

  assign inst_valid = head_is_prefix ? (count_q >= cnt_t'(2)) : (count_q >= cnt_t'(1));

  // Holding at most DEPTH-4 leaves room for the word in flight plus this one.
  assign req = !rst_i && !flush_i && (count_q <= REQ_LIMIT);

  // A response counts only if a request went out in the previous cycle.
  // This drops anything that shows up right after reset.
  assign push   = bus.imem_valid_i && req_q && !flush_i;
  assign push_n = !push ? cnt_t'(0) : (skip_low_q ? cnt_t'(1) : cnt_t'(2));
  assign pop    = inst_valid && !stall_i && !flush_i;
  assign pop_n  = !pop ? cnt_t'(0) : (head_is_prefix ? cnt_t'(2) : cnt_t'(1));

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = fetch_pc_q;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = head_is_prefix ? {head_hi, head_lo} : {16'h0000, head_lo};
  assign bus.inst_is_32_o = head_is_prefix;
  assign bus.inst_pc_o    = head_pc_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and evaluation order inside the block is irrelevant.
  always_ff @(posedge clk_i) begin
    req_q <= req;
    if (rst_i) begin
      // NOTE: the halfword array is reset deliberately: inst_o must read as zero
      // straight after reset, and the outputs are driven from these entries directly.
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_FETCH;
      head_pc_q  <= RESET_PC;
      skip_low_q <= RESET_PC[1];
    end else if (flush_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= {flush_pc_i[31:2], 2'b00};
      head_pc_q  <= flush_pc_i;
      skip_low_q <= flush_pc_i[1];
    end else begin
      if (req) fetch_pc_q <= fetch_pc_q + 32'd4;
      if (push) begin
        if (skip_low_q) begin
          mem_q[tail_q] <= bus.imem_data_i[31:16];
          tail_q        <= tail_q + ptr_t'(1);
          skip_low_q    <= 1'b0;
        end else begin
          mem_q[tail_q]              <= bus.imem_data_i[15:0];
          mem_q[tail_q + ptr_t'(1)]  <= bus.imem_data_i[31:16];
          tail_q                     <= tail_q + ptr_t'(2);
        end
      end
      if (pop) begin
        head_q    <= head_q + (head_is_prefix ? ptr_t'(2) : ptr_t'(1));
        head_pc_q <= head_pc_q + (head_is_prefix ? 32'd4 : 32'd2);
      end
      count_q <= count_q + push_n - pop_n;
    end
  end

  a_resp_has_req: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_valid_i |-> req_q);

endmodule
